ctrl_decode_pipe: RTL
=====================

CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 The module SHALL have parameter EN_M, default 1, meaning RV32M mul/div decode is enabled (0 means funct7=0000001 R-type is illegal).
REQ-002 The module SHALL have parameter DIV_LATENCY, default 32, meaning total E-stage occupancy in cycles of a div/rem op; legal range is 2..255.
REQ-003 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 instr_d  input  32  D-stage instruction (opcode [6:0], funct3 [14:12], funct7 [31:25]).
REQ-007 valid_d  input  1  instr_d holds a real instruction.
REQ-008 stall_e  input  1  hazard-unit hold of the E register.
REQ-009 flush_e  input  1  hazard-unit bubble insert into E.
REQ-010 imm_src_d  output  3  combinational immediate select for the D-stage extender.
REQ-011 Registered E-stage outputs SHALL be: reg_write_e 1, mem_write_e 1, branch_e 1, jump_e 1, jump_reg_e 1, alu_src_e 1, src_a_src_e 1, result_src_e 2, alu_op_e 2, muldiv_e 1, illegal_e 1, valid_e 1.
REQ-012 mc_busy  output  1  multi-cycle op occupies E; upstream SHALL stall D and F.

Function
REQ-013 Decode SHALL be combinational from instr_d; every field not listed for an opcode SHALL be 0.
REQ-014 For 0000011 (load), decode SHALL give reg_write=1, imm=000, alu_src=1, result_src=01, alu_op=00.
REQ-015 For 0100011 (store), decode SHALL give imm=001, alu_src=1, mem_write=1.
REQ-016 For 0110011 (R), decode SHALL give reg_write=1, alu_op=10.
REQ-017 For 0010011 (I-ALU), decode SHALL give reg_write=1, alu_src=1, alu_op=10.
REQ-018 For 1100011 (branch), decode SHALL give imm=010, branch=1, alu_op=01.
REQ-019 For 0110111 (lui), decode SHALL give reg_write=1, imm=100, alu_src=1, result_src=11.
REQ-020 For 0010111 (auipc), decode SHALL give reg_write=1, imm=100, alu_src=1, src_a_src=1.
REQ-021 For 1101111 (jal), decode SHALL give reg_write=1, imm=011, result_src=10, jump=1, src_a_src=1.
REQ-022 For 1100111 (jalr), decode SHALL give reg_write=1, imm=000, result_src=10, jump=1, jump_reg=1; jump_reg SHALL be 1 only for jalr.
REQ-023 R-type funct7 SHALL be legal when it is 0000000, 0100000, or (EN_M=1 and 0000001); funct7=0000001 with EN_M=1 SHALL set muldiv=1.
REQ-024 Any other opcode or funct7 SHALL be illegal: all controls 0, illegal=1.
REQ-025 The E register SHALL update as follows, in priority order: flush_e gives a bubble (all E outputs 0); else mc_busy=1 or stall_e=1 gives hold; else load the decode, with valid_e=valid_d and all controls gated to 0 when valid_d=0.
REQ-026 The FSM SHALL have states IDLE and BUSY with an 8-bit counter cnt.
REQ-027 In IDLE, loading a valid muldiv op with funct3[2]=1 (div/rem) SHALL move to BUSY with cnt=DIV_LATENCY-1.
REQ-028 mul ops (funct3[2]=0) SHALL be single-cycle and SHALL cause no BUSY.
REQ-029 In BUSY, mc_busy SHALL be 1 and cnt SHALL decrement every cycle regardless of stall_e.
REQ-030 In BUSY with cnt==1, the next state SHALL be IDLE and cnt SHALL become 0.
REQ-031 A div SHALL occupy E for exactly DIV_LATENCY cycles absent stall/flush, with mc_busy high for DIV_LATENCY-1 of them.
REQ-032 flush_e in BUSY SHALL abort: next state IDLE, cnt=0, E bubble.
REQ-033 mc_busy SHALL be a registered output, equal to (state==BUSY).

Reset
REQ-034 On rst_n=0, asynchronously: all E outputs=0, mc_busy=0, state=IDLE, cnt=0.
REQ-035 Reset SHALL abort an in-flight div with no residual busy after release.
REQ-036 imm_src_d SHALL be unaffected by reset (combinational).

Verification
REQ-037 lw x1,0(x2) (0x00012083), valid_d=1 -> next cycle reg_write_e=1, alu_src_e=1, result_src_e=01, valid_e=1, illegal_e=0.
REQ-038 jalr (opcode 1100111) -> jump_e=1, jump_reg_e=1, result_src_e=10; jal -> jump_reg_e=0, src_a_src_e=1, imm_src_d=011.
REQ-039 div (funct7 0000001, funct3 100), DIV_LATENCY=4 -> mc_busy high 3 cycles, E held 4 cycles, then the next instruction loads.
REQ-040 EN_M=0 with mul -> illegal_e=1, all controls 0; opcode 1111111 -> illegal_e=1.
REQ-041 flush_e and stall_e asserted together -> bubble; flush_e during BUSY with cnt=2 -> mc_busy=0 next cycle.
REQ-042 rst_n low mid-div -> outputs 0 immediately; after release a new lw loads in 1 cycle.

Source files
------------

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: RV32I/M main decoder feeding the D->E pipeline register,
// with a small occupancy FSM that holds E while a div/rem op runs.
module ctrl_decode_pipe #(
   parameter bit          EN_M        = 1'b1,
   parameter int unsigned DIV_LATENCY = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr_d,
   input  logic        valid_d,
   input  logic        stall_e,
   input  logic        flush_e,
   output logic [2:0]  imm_src_d,
   output logic        reg_write_e,
   output logic        mem_write_e,
   output logic        branch_e,
   output logic        jump_e,
   output logic        jump_reg_e,
   output logic        alu_src_e,
   output logic        src_a_src_e,
   output logic [1:0]  result_src_e,
   output logic [1:0]  alu_op_e,
   output logic        muldiv_e,
   output logic        illegal_e,
   output logic        valid_e,
   output logic        mc_busy
);

   localparam int unsigned CNT_W    = 8;
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;
   localparam logic [6:0] F7_MULDV = 7'b0000001;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       jump_reg;
      logic       alu_src;
      logic       src_a_src;
      logic [1:0] result_src;
      logic [1:0] alu_op;
      logic       muldiv;
      logic       illegal;
   } ctrl_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   logic [6:0]       w_opcode;
   logic [6:0]       w_funct7;
   logic             w_is_div;
   ctrl_t            w_dec;
   logic [2:0]       w_imm;
   logic             w_load;
   logic             w_unused;

   ctrl_t            r_ctrl;
   logic             r_valid;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_mc_busy;

   assign w_opcode = instr_d[6:0];
   assign w_funct7 = instr_d[31:25];
   assign w_is_div = instr_d[14];
   assign w_unused = ^{instr_d[24:15], instr_d[13:7]};

   // Main decode: opcode/funct7 to control bundle and immediate select.
   always_comb begin
      w_dec = '0;
      w_imm = 3'b000;
      case (w_opcode)
         OP_LOAD: begin
            w_dec.reg_write  = 1'b1;
            w_dec.alu_src    = 1'b1;
            w_dec.result_src = 2'b01;
            w_imm            = 3'b000;
         end
         OP_STORE: begin
            w_dec.mem_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_imm           = 3'b001;
         end
         OP_R: begin
            if (w_funct7 == F7_BASE || w_funct7 == F7_ALT) begin
               w_dec.reg_write = 1'b1;
               w_dec.alu_op    = 2'b10;
            end else if (EN_M && w_funct7 == F7_MULDV) begin
               w_dec.reg_write = 1'b1;
               w_dec.alu_op    = 2'b10;
               w_dec.muldiv    = 1'b1;
            end else begin
               w_dec.illegal   = 1'b1;
            end
         end
         OP_IALU: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.alu_op    = 2'b10;
         end
         OP_BR: begin
            w_dec.branch = 1'b1;
            w_dec.alu_op = 2'b01;
            w_imm        = 3'b010;
         end
         OP_LUI: begin
            w_dec.reg_write  = 1'b1;
            w_dec.alu_src    = 1'b1;
            w_dec.result_src = 2'b11;
            w_imm            = 3'b100;
         end
         OP_AUIPC: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.src_a_src = 1'b1;
            w_imm           = 3'b100;
         end
         OP_JAL: begin
            w_dec.reg_write  = 1'b1;
            w_dec.result_src = 2'b10;
            w_dec.jump       = 1'b1;
            w_dec.src_a_src  = 1'b1;
            w_imm            = 3'b011;
         end
         OP_JALR: begin
            w_dec.reg_write  = 1'b1;
            w_dec.result_src = 2'b10;
            w_dec.jump       = 1'b1;
            w_dec.jump_reg   = 1'b1;
            w_imm            = 3'b000;
         end
         default: begin
            w_dec.illegal = 1'b1;
         end
      endcase
   end

   assign imm_src_d = w_imm;

   // E accepts a new instruction only when neither flushed, held, nor occupied.
   assign w_load = !flush_e && !r_mc_busy && !stall_e;

   // E pipeline register: flush beats hold beats load; invalid slots carry no controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl  <= '0;
         r_valid <= 1'b0;
      end else if (flush_e) begin
         r_ctrl  <= '0;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_ctrl  <= valid_d ? w_dec : '0;
         r_valid <= valid_d;
      end
   end

   // Occupancy FSM next-state: a loaded div/rem counts down its remaining cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_load && valid_d && w_dec.muldiv && w_is_div) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = DIV_LOAD;
            end
         end
         ST_BUSY: begin
            if (flush_e || r_cnt == CNT_W'(1)) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Occupancy FSM state, counter and registered busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_mc_busy <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_mc_busy <= (w_state_nxt == ST_BUSY);
      end
   end

   assign reg_write_e  = r_ctrl.reg_write;
   assign mem_write_e  = r_ctrl.mem_write;
   assign branch_e     = r_ctrl.branch;
   assign jump_e       = r_ctrl.jump;
   assign jump_reg_e   = r_ctrl.jump_reg;
   assign alu_src_e    = r_ctrl.alu_src;
   assign src_a_src_e  = r_ctrl.src_a_src;
   assign result_src_e = r_ctrl.result_src;
   assign alu_op_e     = r_ctrl.alu_op;
   assign muldiv_e     = r_ctrl.muldiv;
   assign illegal_e    = r_ctrl.illegal;
   assign valid_e      = r_valid;
   assign mc_busy      = r_mc_busy;

endmodule
